// File: rtl/wb_pkg.sv
// Shared widths, special register numbers and the writeback queue entry type
// for the register-file write controller.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] LINK_REG = ADDR_W'(31);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(0);

  typedef struct packed {
    logic              link;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Register actually written by an entry; link writes always land in $31.
  function automatic logic [ADDR_W-1:0] wb_target(input wb_entry_t e);
    return e.link ? LINK_REG : e.dst;
  endfunction

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Writeback bus between the pipeline and reg_writeback_ctrl. WB_FWD_EN adds
// the combinational forwarding outputs.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// producer holds dst/data/link stable while valid is high, and ready never
// depends on the same source's valid.
interface reg_writeback_ctrl_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_link;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dst;
  logic [DATA_W-1:0] mem_data;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_dst;
  logic [ADDR_W-1:0] rs_add;
  logic [ADDR_W-1:0] rt_add;
  logic              rs_busy;
  logic              rt_busy;
  logic              WE_reg;
  logic              ra_enable;
  logic [ADDR_W-1:0] rd_add;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ra_data;
`ifdef WB_FWD_EN
  logic              rs_fwd_valid;
  logic [DATA_W-1:0] rs_fwd_data;
  logic              rt_fwd_valid;
  logic [DATA_W-1:0] rt_fwd_data;

  modport master (
    output alu_valid, alu_dst, alu_data, alu_link,
    output mem_valid, mem_dst, mem_data,
    output sb_set, sb_dst, rs_add, rt_add,
    input  alu_ready, mem_ready, rs_busy, rt_busy,
    input  WE_reg, ra_enable, rd_add, rd_data, ra_data,
    input  rs_fwd_valid, rs_fwd_data, rt_fwd_valid, rt_fwd_data
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data, alu_link,
    input  mem_valid, mem_dst, mem_data,
    input  sb_set, sb_dst, rs_add, rt_add,
    output alu_ready, mem_ready, rs_busy, rt_busy,
    output WE_reg, ra_enable, rd_add, rd_data, ra_data,
    output rs_fwd_valid, rs_fwd_data, rt_fwd_valid, rt_fwd_data
  );
`else
  modport master (
    output alu_valid, alu_dst, alu_data, alu_link,
    output mem_valid, mem_dst, mem_data,
    output sb_set, sb_dst, rs_add, rt_add,
    input  alu_ready, mem_ready, rs_busy, rt_busy,
    input  WE_reg, ra_enable, rd_add, rd_data, ra_data
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data, alu_link,
    input  mem_valid, mem_dst, mem_data,
    input  sb_set, sb_dst, rs_add, rt_add,
    output alu_ready, mem_ready, rs_busy, rt_busy,
    output WE_reg, ra_enable, rd_add, rd_data, ra_data
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. With WB_FWD_EN it also exposes its
// storage, read pointer and count so the top can search it for forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
`ifdef WB_FWD_EN
  ,
  output wb_entry_t                    entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0]     rd_ptr,
  output logic [$clog2(DEPTH):0]       count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem_q [DEPTH];
  wb_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // Callers never push at full or pop at empty; the guards keep state sane anyway.
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

`ifdef WB_FWD_EN
  assign entries = mem_q;
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;
`endif

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write controller: arbitrates ALU/load results into a FIFO,
// drains one registered write per cycle and keeps the busy scoreboard.
// Optional macro WB_FWD_EN adds combinational rs/rt forwarding outputs.
module reg_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_writeback_ctrl_if.slave bus
);

  localparam int NREG = 1 << ADDR_W;

  logic      full, empty;
  wb_entry_t head;
  logic      mem_hs, alu_hs, push, pop;
  wb_entry_t in_entry;

  logic              we_q, we_d;
  logic              ra_en_q, ra_en_d;
  logic [ADDR_W-1:0] rd_add_q, rd_add_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] ra_data_q, ra_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

`ifdef WB_FWD_EN
  wb_entry_t                fifo_entries [DEPTH];
  logic [$clog2(DEPTH)-1:0] fifo_rd_ptr;
  logic [$clog2(DEPTH):0]   fifo_count;
`endif

  // Loads win arbitration; readies look only at the registered full flag.
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;
  assign mem_hs        = bus.mem_valid && bus.mem_ready;
  assign alu_hs        = bus.alu_valid && bus.alu_ready;

  always_comb begin
    in_entry = '0;
    if (mem_hs) begin
      in_entry.link = 1'b0;
      in_entry.dst  = bus.mem_dst;
      in_entry.data = bus.mem_data;
    end else begin
      in_entry.link = bus.alu_link;
      in_entry.dst  = bus.alu_link ? LINK_REG : bus.alu_dst;
      in_entry.data = bus.alu_data;
    end
  end

  // Non-link writes to $0 complete the handshake but never reach the queue.
  assign push = (mem_hs || alu_hs) && (in_entry.link || in_entry.dst != ZERO_REG);
  assign pop  = !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head)
`ifdef WB_FWD_EN
    ,
    .entries    (fifo_entries),
    .rd_ptr     (fifo_rd_ptr),
    .count      (fifo_count)
`endif
  );

  always_comb begin
    we_d      = pop;
    ra_en_d   = pop && head.link;
    rd_add_d  = pop ? wb_target(head) : rd_add_q;
    rd_data_d = (pop && !head.link) ? head.data : rd_data_q;
    ra_data_d = (pop && head.link) ? head.data : ra_data_q;
  end

  // Clear the register being committed this edge, then apply the new set so set wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[rd_add_q] = 1'b0;
    end
    if (bus.sb_set && bus.sb_dst != ZERO_REG) begin
      busy_d[bus.sb_dst] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      ra_en_q   <= 1'b0;
      rd_add_q  <= '0;
      rd_data_q <= '0;
      ra_data_q <= '0;
      busy_q    <= '0;
    end else begin
      we_q      <= we_d;
      ra_en_q   <= ra_en_d;
      rd_add_q  <= rd_add_d;
      rd_data_q <= rd_data_d;
      ra_data_q <= ra_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.WE_reg    = we_q;
  assign bus.ra_enable = ra_en_q;
  assign bus.rd_add    = rd_add_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.ra_data   = ra_data_q;
  assign bus.rs_busy   = busy_q[bus.rs_add];
  assign bus.rt_busy   = busy_q[bus.rt_add];

`ifdef WB_FWD_EN
  // Oldest candidate first (the write port), so later FIFO matches overwrite it.
  always_comb begin
    wb_entry_t e;
    logic [$clog2(DEPTH)-1:0] idx;
    logic [DATA_W-1:0] port_data;
    bus.rs_fwd_valid = 1'b0;
    bus.rs_fwd_data  = '0;
    bus.rt_fwd_valid = 1'b0;
    bus.rt_fwd_data  = '0;
    e                = '0;
    idx              = '0;
    port_data        = ra_en_q ? ra_data_q : rd_data_q;
    if (we_q && rd_add_q != ZERO_REG) begin
      if (rd_add_q == bus.rs_add) begin
        bus.rs_fwd_valid = 1'b1;
        bus.rs_fwd_data  = port_data;
      end
      if (rd_add_q == bus.rt_add) begin
        bus.rt_fwd_valid = 1'b1;
        bus.rt_fwd_data  = port_data;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = fifo_rd_ptr + ($clog2(DEPTH))'(i);
      e   = fifo_entries[idx];
      if (($clog2(DEPTH)+1)'(i) < fifo_count && wb_target(e) != ZERO_REG) begin
        if (wb_target(e) == bus.rs_add) begin
          bus.rs_fwd_valid = 1'b1;
          bus.rs_fwd_data  = e.data;
        end
        if (wb_target(e) == bus.rt_add) begin
          bus.rt_fwd_valid = 1'b1;
          bus.rt_fwd_data  = e.data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Randomized self-checking bench for reg_writeback_ctrl against a queue-based
// reference model of accepted writes and a per-register busy model.
module tb_reg_writeback_ctrl;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if bus();

  reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;

  wb_entry_t   exp_q[$];      // accepted writes not yet presented on the port
  logic        m_we, m_ra;
  logic [4:0]  m_rd_add;
  logic [31:0] m_rd_data, m_ra_data;
  logic [31:0] m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_we      = 1'b0;
    m_ra      = 1'b0;
    m_rd_add  = '0;
    m_rd_data = '0;
    m_ra_data = '0;
    m_busy    = '0;
  endtask

  // Apply the behaviour of one rising edge given the inputs held during it.
  task automatic model_edge();
    logic [31:0] nb;
    logic        room, mem_hs, alu_hs;
    wb_entry_t   e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nb = m_busy;
    if (m_we) nb[m_ra ? 5'd31 : m_rd_add] = 1'b0;
    if (bus.sb_set && bus.sb_dst != 5'd0) nb[bus.sb_dst] = 1'b1;
    nb[0] = 1'b0;
    room   = exp_q.size() < DEPTH;
    mem_hs = bus.mem_valid && room;
    alu_hs = bus.alu_valid && room && !bus.mem_valid;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      m_we = 1'b1;
      if (e.link) begin
        m_ra      = 1'b1;
        m_rd_add  = 5'd31;
        m_ra_data = e.data;
      end else begin
        m_ra      = 1'b0;
        m_rd_add  = e.dst;
        m_rd_data = e.data;
      end
    end else begin
      m_we = 1'b0;
      m_ra = 1'b0;
    end
    if (mem_hs) begin
      if (bus.mem_dst != 5'd0) exp_q.push_back('{link: 1'b0, dst: bus.mem_dst, data: bus.mem_data});
    end else if (alu_hs) begin
      if (bus.alu_link)
        exp_q.push_back('{link: 1'b1, dst: 5'd31, data: bus.alu_data});
      else if (bus.alu_dst != 5'd0)
        exp_q.push_back('{link: 1'b0, dst: bus.alu_dst, data: bus.alu_data});
    end
    m_busy = nb;
  endtask

  task automatic compare_outputs();
    logic room;
    room = exp_q.size() < DEPTH;
    check("mem_ready", 32'(bus.mem_ready), 32'(room));
    check("alu_ready", 32'(bus.alu_ready), 32'(room && !bus.mem_valid));
    check("rs_busy",   32'(bus.rs_busy),   32'(m_busy[bus.rs_add]));
    check("rt_busy",   32'(bus.rt_busy),   32'(m_busy[bus.rt_add]));
    check("WE_reg",    32'(bus.WE_reg),    32'(m_we));
    check("ra_enable", 32'(bus.ra_enable), 32'(m_ra));
    check("rd_add",    32'(bus.rd_add),    32'(m_rd_add));
    check("rd_data",   bus.rd_data,        m_rd_data);
    check("ra_data",   bus.ra_data,        m_ra_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.alu_valid = 1'b0;
    bus.alu_dst   = '0;
    bus.alu_data  = '0;
    bus.alu_link  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_dst   = '0;
    bus.mem_data  = '0;
    bus.sb_set    = 1'b0;
    bus.sb_dst    = '0;
  endtask

  // Inputs are set at the falling edge; check mid-phase, then advance one edge.
  task automatic step();
    #1 compare_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic alu_op(input logic [4:0] dst, input logic [31:0] data, input logic link);
    set_idle();
    bus.alu_valid = 1'b1;
    bus.alu_dst   = dst;
    bus.alu_data  = data;
    bus.alu_link  = link;
    bus.sb_set    = 1'b1;
    bus.sb_dst    = link ? 5'd31 : dst;
    step();
    set_idle();
  endtask

  task automatic randomize_inputs();
    bus.mem_valid = ($urandom_range(0, 3) == 0);
    bus.mem_dst   = 5'($urandom_range(0, 31));
    bus.mem_data  = $urandom;
    bus.alu_valid = ($urandom_range(0, 1) == 0);
    bus.alu_dst   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    bus.alu_data  = $urandom;
    bus.alu_link  = ($urandom_range(0, 7) == 0);
    bus.sb_set    = ($urandom_range(0, 1) == 0);
    bus.sb_dst    = 5'($urandom_range(0, 31));
    bus.rs_add    = 5'($urandom_range(0, 31));
    bus.rt_add    = 5'($urandom_range(0, 31));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_idle();
    bus.rs_add = '0;
    bus.rt_add = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Plain ALU write to $5
    bus.rs_add = 5'd5;
    alu_op(5'd5, 32'h0000_1234, 1'b0);
    repeat (3) step();

    // Link write lands in $31 via ra_data
    bus.rs_add = 5'd31;
    alu_op(5'd7, 32'h0040_0010, 1'b1);
    repeat (3) step();

    // Load and ALU offered together with distinct destinations
    for (int i = 0; i < 6; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_dst   = 5'(10 + i);
      bus.mem_data  = 32'hA000_0000 + 32'(i);
      bus.alu_valid = 1'b1;
      bus.alu_dst   = 5'(20 + i);
      bus.alu_data  = 32'hB000_0000 + 32'(i);
      bus.rt_add    = 5'(10 + i);
      step();
    end
    set_idle();
    repeat (3) step();

    // Write to $0 is swallowed
    bus.rs_add = 5'd0;
    bus.alu_valid = 1'b1;
    bus.alu_dst   = 5'd0;
    bus.alu_data  = 32'h0000_FFFF;
    bus.sb_set    = 1'b1;
    bus.sb_dst    = 5'd0;
    step();
    set_idle();
    repeat (3) step();

    // Re-issue to $8 on the same edge its previous write commits
    bus.rs_add = 5'd8;
    alu_op(5'd8, 32'h0000_0888, 1'b0);
    step();
    bus.sb_set = 1'b1;
    bus.sb_dst = 5'd8;
    step();
    set_idle();
    repeat (3) step();

    // Reset while writes are in flight
    alu_op(5'd3, 32'h3333_3333, 1'b0);
    alu_op(5'd4, 32'h4444_4444, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();

    // Random traffic with occasional resets
    for (int c = 0; c < 500; c++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 59) != 0);
      step();
    end
    set_idle();
    rst_n = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
